// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state encoding and key constants for the password lock
package lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SET_ENTRY  = 3'd1,
        ST_TEST_ENTRY = 3'd2,
        ST_PASS       = 3'd3,
        ST_FAIL       = 3'd4,
        ST_LOCKED     = 3'd5
    } state_t;

    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/entry_buf.sv
// rtl/entry_buf.sv - digit entry shift register with saturating count and backspace
module entry_buf #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [3:0]            code,
    output logic [DIGITS*4-1:0]   buffer,
    output logic [1:0]            cnt
);

    // clear wins over push/pop; a full buffer drops further digits instead of wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buffer <= '0;
            cnt    <= '0;
        end else if (clear) begin
            buffer <= '0;
            cnt    <= '0;
        end else if (push && cnt != 2'(DIGITS)) begin
            buffer <= {buffer[DIGITS*4-5:0], code};
            cnt    <= cnt + 2'd1;
        end else if (pop && cnt != 2'd0) begin
            buffer <= buffer >> 4;
            cnt    <= cnt - 2'd1;
        end
    end

endmodule

// File: rtl/lock_ctrl.sv
// rtl/lock_ctrl.sv - keypad lock sequencer; LOCK_CTRL_BACKSPACE_EN enables key B as backspace
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int DIGITS     = 3,
    parameter int MAX_FAIL   = 3,
    parameter int RESULT_CYC = 20,
    parameter int LOCK_CYC   = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    input  logic                set_password,
    input  logic                enter,
    input  logic                test,
    output logic [DIGITS*4-1:0] disp_digits,
    output logic [1:0]          disp_cnt,
    output logic [2:0]          state_o,
    output logic                gled0,
    output logic                gled1,
    output logic                rled0,
    output logic                rled1,
    output logic                rled2
);

    localparam int TMAX = (RESULT_CYC > LOCK_CYC) ? RESULT_CYC : LOCK_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    state_t                state;
    logic [DIGITS*4-1:0]   password;
    logic                  pw_valid;
    logic [1:0]            fail_cnt;
    logic [TW-1:0]         timer;
    logic [DIGITS*4-1:0]   buffer;
    logic [1:0]            cnt;

    logic in_entry, key_ok, push, pop, clear, result_done, entry_full;

    assign in_entry    = (state == ST_SET_ENTRY) || (state == ST_TEST_ENTRY);
    assign key_ok      = key_valid && !set_password && !test && !enter && in_entry;
    assign push        = key_ok && (key_code <= DIGIT_MAX);
    assign result_done = (timer == TW'(RESULT_CYC - 1));
    assign entry_full  = (cnt == 2'(DIGITS));

`ifdef LOCK_CTRL_BACKSPACE_EN
    assign pop = key_ok && (key_code == KEY_BKSP);
`else
    assign pop = 1'b0;
`endif

    // every path into an entry state, and the timed return from PASS/FAIL, empties the buffer
    assign clear = (set_password && state != ST_LOCKED)
                || (state == ST_IDLE && !set_password && test && pw_valid)
                || ((state == ST_PASS || state == ST_FAIL) && !set_password && result_done);

    entry_buf #(.DIGITS(DIGITS)) u_entry_buf (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .push   (push),
        .pop    (pop),
        .code   (key_code),
        .buffer (buffer),
        .cnt    (cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            password <= '0;
            pw_valid <= 1'b0;
            fail_cnt <= '0;
            timer    <= '0;
        end else begin
            timer <= '0;
            case (state)
                ST_IDLE: begin
                    if (set_password)        state <= ST_SET_ENTRY;
                    else if (test && pw_valid) state <= ST_TEST_ENTRY;
                end
                ST_SET_ENTRY: begin
                    if (!set_password && !test && enter && entry_full) begin
                        password <= buffer;
                        pw_valid <= 1'b1;
                        fail_cnt <= '0;
                        state    <= ST_IDLE;
                    end
                end
                ST_TEST_ENTRY: begin
                    if (set_password) begin
                        state <= ST_SET_ENTRY;
                    end else if (!test && enter) begin
                        if (entry_full && buffer == password) begin
                            fail_cnt <= '0;
                            state    <= ST_PASS;
                        end else begin
                            fail_cnt <= fail_cnt + 2'd1;
                            state    <= (fail_cnt + 2'd1 == 2'(MAX_FAIL)) ? ST_LOCKED : ST_FAIL;
                        end
                    end
                end
                ST_PASS, ST_FAIL: begin
                    if (set_password)     state <= ST_SET_ENTRY;
                    else if (result_done) state <= ST_IDLE;
                    else                  timer <= timer + 1'b1;
                end
                ST_LOCKED: begin
                    if (timer == TW'(LOCK_CYC - 1)) begin
                        fail_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign disp_digits = buffer;
    assign disp_cnt    = cnt;
    assign state_o     = state;
    assign gled0       = pw_valid;
    assign gled1       = (state == ST_PASS);
    assign rled0       = (state == ST_LOCKED) || (fail_cnt > 2'd0);
    assign rled1       = (state == ST_LOCKED) || (fail_cnt > 2'd1);
    assign rled2       = (state == ST_LOCKED) || (fail_cnt > 2'd2);

endmodule

// File: tb/tb_lock_ctrl.sv
// tb/tb_lock_ctrl.sv - directed and randomized self-checking bench for lock_ctrl
module tb_lock_ctrl;

    localparam int S_IDLE = 0, S_SET = 1, S_TEST = 2, S_PASS = 3, S_FAIL = 4, S_LOCKED = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        set_password = 1'b0;
    logic        enter = 1'b0;
    logic        test = 1'b0;
    logic [11:0] disp_digits;
    logic [1:0]  disp_cnt;
    logic [2:0]  state_o;
    logic        gled0, gled1, rled0, rled1, rled2;

    always #5 clk = ~clk;

    lock_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .set_password (set_password),
        .enter        (enter),
        .test         (test),
        .disp_digits  (disp_digits),
        .disp_cnt     (disp_cnt),
        .state_o      (state_o),
        .gled0        (gled0),
        .gled1        (gled1),
        .rled0        (rled0),
        .rled1        (rled1),
        .rled2        (rled2)
    );

    int n_run  = 0;
    int n_fail = 0;

    int          m_state = S_IDLE;
    int          q[$];
    logic [11:0] m_pw = '0;
    bit          m_valid = 1'b0;
    int          m_fail = 0;
    int          m_left = 0;

    function automatic logic [11:0] packq();
        logic [11:0] v = '0;
        foreach (q[i]) v = {v[7:0], 4'(q[i])};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_key(input int code);
        if (code <= 9 && q.size() < 3) q.push_back(code);
`ifdef LOCK_CTRL_BACKSPACE_EN
        else if (code == 11 && q.size() > 0) void'(q.pop_back());
`endif
    endtask

    task automatic model_step(input bit s, input bit t, input bit e, input bit kv, input int code);
        case (m_state)
            S_IDLE: begin
                if (s) begin m_state = S_SET; q.delete(); end
                else if (t && m_valid) begin m_state = S_TEST; q.delete(); end
            end
            S_SET: begin
                if (s) q.delete();
                else if (t) ;
                else if (e) begin
                    if (q.size() == 3) begin
                        m_pw = packq(); m_valid = 1; m_fail = 0; m_state = S_IDLE;
                    end
                end else if (kv) model_key(code);
            end
            S_TEST: begin
                if (s) begin m_state = S_SET; q.delete(); end
                else if (t) ;
                else if (e) begin
                    if (q.size() == 3 && packq() == m_pw) begin
                        m_state = S_PASS; m_fail = 0; m_left = 20;
                    end else begin
                        m_fail++;
                        if (m_fail == 3) begin m_state = S_LOCKED; m_left = 100; end
                        else begin m_state = S_FAIL; m_left = 20; end
                    end
                end else if (kv) model_key(code);
            end
            S_PASS, S_FAIL: begin
                if (s) begin m_state = S_SET; q.delete(); end
                else begin
                    m_left--;
                    if (m_left == 0) begin m_state = S_IDLE; q.delete(); end
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin m_state = S_IDLE; m_fail = 0; end
            end
        endcase
    endtask

    task automatic model_reset();
        m_state = S_IDLE; q.delete(); m_pw = '0; m_valid = 0; m_fail = 0; m_left = 0;
    endtask

    task automatic check_model(input string tag);
        int exp_rled;
        exp_rled = (m_state == S_LOCKED) ? 7 : ((1 << m_fail) - 1);
        chk({tag, ".digits"}, 16'(disp_digits), 16'(packq()));
        chk({tag, ".cnt"},    16'(disp_cnt),    16'(q.size()));
        chk({tag, ".state"},  16'(state_o),     16'(m_state));
        chk({tag, ".gled0"},  16'(gled0),       16'(m_valid));
        chk({tag, ".gled1"},  16'(gled1),       16'(m_state == S_PASS));
        chk({tag, ".rled"},   16'({rled2, rled1, rled0}), 16'(exp_rled));
    endtask

    task automatic tick(input bit s, input bit t, input bit e, input bit kv, input logic [3:0] code);
        set_password = s; test = t; enter = e; key_valid = kv; key_code = code;
        @(posedge clk);
        model_step(s, t, e, kv, int'(code));
        #1;
        set_password = 0; test = 0; enter = 0; key_valid = 0; key_code = 4'h0;
        check_model("step");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 4'h0);
    endtask

    task automatic key(input logic [3:0] c);
        tick(0, 0, 0, 1, c);
    endtask

    task automatic attempt(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        tick(0, 1, 0, 0, 4'h0);
        key(a); key(b); key(c);
        tick(0, 0, 1, 0, 4'h0);
    endtask

    initial begin
        // reset
        repeat (2) @(posedge clk);
        #1;
        chk("reset.state", 16'(state_o), 16'(S_IDLE));
        chk("reset.outs", 16'({disp_digits, disp_cnt, gled0, gled1, rled0, rled1, rled2}), 16'h0);
        rst = 1'b1;
        idle(2);

        // test without stored password is ignored
        tick(0, 1, 0, 0, 4'h0);
        chk("nopw.state", 16'(state_o), 16'(S_IDLE));

        // saturation at three digits
        tick(1, 0, 0, 0, 4'h0);
        for (int i = 0; i < 4; i++) key(4'h5);
        chk("sat.digits", 16'(disp_digits), 16'h555);
        chk("sat.cnt", 16'(disp_cnt), 16'd3);

        // set_password with simultaneous key restarts with empty buffer
        tick(1, 0, 0, 1, 4'h7);
        chk("collide.state", 16'(state_o), 16'(S_SET));
        chk("collide.cnt", 16'(disp_cnt), 16'd0);

        // short enter is ignored, then program 123
        key(4'h1); key(4'h2);
        tick(0, 0, 1, 0, 4'h0);
        chk("short.state", 16'(state_o), 16'(S_SET));
        key(4'h3);
        tick(0, 0, 1, 0, 4'h0);
        chk("prog.gled0", 16'(gled0), 16'd1);
        chk("prog.state", 16'(state_o), 16'(S_IDLE));
        chk("prog.pw", 16'(m_pw), 16'h123);

        // correct attempt: PASS held for 20 cycles
        attempt(4'h1, 4'h2, 4'h3);
        chk("pass.gled1", 16'(gled1), 16'd1);
        for (int i = 0; i < 19; i++) begin
            tick(0, 0, 0, 0, 4'h0);
            chk("pass.hold", 16'(gled1), 16'd1);
        end
        tick(0, 0, 0, 0, 4'h0);
        chk("pass.done", 16'({state_o, disp_cnt}), 16'({3'(S_IDLE), 2'd0}));
        chk("pass.rled", 16'({rled2, rled1, rled0}), 16'd0);

        // three wrong attempts lead to lockout
        attempt(4'h1, 4'h2, 4'h4);
        chk("bad1.rled", 16'({rled2, rled1, rled0}), 16'b001);
        idle(20);
        attempt(4'h1, 4'h2, 4'h4);
        chk("bad2.rled", 16'({rled2, rled1, rled0}), 16'b011);
        idle(20);
        attempt(4'h1, 4'h2, 4'h4);
        chk("bad3.state", 16'(state_o), 16'(S_LOCKED));
        chk("bad3.rled", 16'({rled2, rled1, rled0}), 16'b111);
        for (int i = 0; i < 99; i++) begin
            tick(i % 3 == 0, i % 3 == 1, i % 5 == 0, 1'b1, 4'(i));
            chk("locked.hold", 16'(state_o), 16'(S_LOCKED));
        end
        tick(0, 0, 0, 0, 4'h0);
        chk("unlock.state", 16'(state_o), 16'(S_IDLE));
        chk("unlock.rled", 16'({rled2, rled1, rled0}), 16'd0);

        // backspace handling
        tick(0, 1, 0, 0, 4'h0);
        key(4'h1); key(4'h2); key(4'hB); key(4'h7);
`ifdef LOCK_CTRL_BACKSPACE_EN
        chk("bksp.digits", 16'(disp_digits), 16'h017);
        chk("bksp.cnt", 16'(disp_cnt), 16'd2);
`else
        chk("bksp.digits", 16'(disp_digits), 16'h127);
        chk("bksp.cnt", 16'(disp_cnt), 16'd3);
`endif
        // abandon attempt into programming; fail count unchanged
        tick(1, 0, 0, 0, 4'h0);
        chk("abandon.state", 16'(state_o), 16'(S_SET));
        key(4'h1); key(4'h2); key(4'h3);
        tick(0, 0, 1, 0, 4'h0);

        // randomized pulses against the model
        for (int i = 0; i < 1500; i++) begin
            bit s, t, e, kv;
            logic [3:0] c;
            s  = ($urandom_range(0, 59) == 0);
            t  = ($urandom_range(0, 14) == 0);
            e  = ($urandom_range(0, 7) == 0);
            kv = ($urandom_range(0, 2) == 0);
            c  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
            tick(s, t, e, kv, c);
        end

        // async reset in the middle of a test entry
        idle(120);
        if (!m_valid) begin
            tick(1, 0, 0, 0, 4'h0);
            key(4'h1); key(4'h2); key(4'h3);
            tick(0, 0, 1, 0, 4'h0);
        end
        tick(0, 1, 0, 0, 4'h0);
        key(4'h1);
        chk("prerst.state", 16'(state_o), 16'(S_TEST));
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("asyncrst.outs", 16'({state_o, disp_digits}), 16'h0);
        chk("asyncrst.leds", 16'({disp_cnt, gled0, gled1, rled0, rled1, rled2}), 16'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/lock_ctrl.md
Name: lock_ctrl

Overview:
- Sequencing controller for the keypad password-lock datapath.
- Consumes debounced key events (a one-cycle pulse plus a hex code) from the keypad scanner, and the set_password, enter and test button pulses.
- Owns the entry buffer, the stored password, the comparison, the failure counter and lockout.
- Drives the digit/count bus to the 7-segment display driver and the status LEDs (gled0/1, rled0..2).

Parameters:
- DIGITS, 3: password length in hex digits; entry buffer width is DIGITS*4.
- MAX_FAIL, 3: consecutive failed tests that trigger lockout; 1..3 (one rled per failure).
- RESULT_CYC, 20: cycles the PASS/FAIL indication is held before returning to IDLE.
- LOCK_CYC, 100: cycles spent in LOCKED.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- key_valid  in  1  one-cycle pulse, key_code valid
- key_code  in  4  key value: 0-9 digits, A-F function/extra keys
- set_password  in  1  one-cycle pulse: begin password programming
- enter  in  1  one-cycle pulse: commit current entry
- test  in  1  one-cycle pulse: begin password attempt
- disp_digits  out  DIGITS*4  entry buffer, newest digit in [3:0]
- disp_cnt  out  2  digits currently entered (0..DIGITS)
- state_o  out  3  current FSM state encoding, for display and debug
- gled0  out  1  a password is stored (pw_valid)
- gled1  out  1  unlock success, high in PASS
- rled0, rled1, rled2  out  1 each  failure count as a thermometer code; all high in LOCKED

Behaviour:
- Reset (rst=0, async): state IDLE; buffer, cnt, fail_cnt and timer all 0; stored password 0; pw_valid 0; all outputs 0.
- Input priority when pulses coincide in the same cycle: set_password > test > enter > key_valid. Lower-priority inputs that cycle are dropped.
- States: IDLE, SET_ENTRY, TEST_ENTRY, PASS, FAIL, LOCKED.
- IDLE:
  - set_password: go to SET_ENTRY and clear the buffer.
  - test with pw_valid=1: go to TEST_ENTRY and clear the buffer.
  - test with pw_valid=0: ignored.
  - key and enter: ignored.
- SET_ENTRY / TEST_ENTRY key handling:
  - A key with code <= 9 shifts in: buffer = {buffer[DIGITS*4-5:0], code}, cnt++.
  - Keys are ignored once cnt==DIGITS (no wrap).
  - Codes A-F are ignored, except as described under the optional feature.
  - Outputs update one cycle after key_valid.
- SET_ENTRY enter:
  - cnt==DIGITS: password<=buffer, pw_valid<=1, fail_cnt<=0, go to IDLE.
  - cnt<DIGITS: ignored, stay in SET_ENTRY.
- SET_ENTRY set_password: restarts the entry (buffer cleared).
- TEST_ENTRY enter:
  - buffer==password and cnt==DIGITS: go to PASS and set fail_cnt<=0.
  - Otherwise: fail_cnt++; go to LOCKED if the new fail_cnt==MAX_FAIL, else FAIL.
  - A short entry counts as a failure.
- TEST_ENTRY set_password: abandons the attempt with no fail_cnt change and enters SET_ENTRY.
- PASS / FAIL:
  - Timer counts RESULT_CYC cycles, then the FSM goes to IDLE and the buffer is cleared.
  - set_password aborts to SET_ENTRY. All other inputs are ignored.
- LOCKED:
  - All inputs are ignored, including set_password.
  - After LOCK_CYC cycles: fail_cnt<=0, go to IDLE.
- rled outputs: rled[i] = (fail_cnt > i), or 3'b111 in LOCKED.
- gled1 is high only in PASS. gled0 equals pw_valid.
- Timer: a single counter of width clog2(max(RESULT_CYC, LOCK_CYC)+1), cleared on every state entry.

Optional Feature:
- Macro: LOCK_CTRL_BACKSPACE_EN.
- Defined:
  - key_code 4'hB in an ENTRY state with cnt>0 right-shifts the buffer by 4 (zero fill) and decrements cnt.
  - With cnt==0 the key is a no-op.
- Undefined: 4'hB is ignored like other A-F codes.

Decomposition:
- lock_pkg holds:
  - the state enum (3-bit);
  - key constants: KEY_BKSP=4'hB, DIGIT_MAX=4'd9.
- Sub-module entry_buf:
  - contents: shift register, count, saturation and backspace;
  - interface: clear, push, pop, code in; buffer and cnt out.
- lock_ctrl instantiates entry_buf and holds the FSM, password register, fail counter and timer.

Test Plan:
- Program: set_password, keys 1,2,3, enter -> gled0=1, state IDLE, stored password 12'h123.
- Correct test: test, keys 1,2,3, enter -> gled1=1 for 20 cycles, then IDLE with disp_cnt=0; rled all 0.
- Three bad tests: enter 1,2,4 three times -> rled0, then rled0+1, then LOCKED with all rled=1. Pulses ignored for 100 cycles, then IDLE with rled=0.
- Edge entry:
  - Key 5 pressed 4 times -> disp_cnt saturates at 3 (disp_digits 12'h555).
  - enter in SET_ENTRY with 2 digits -> stays in SET_ENTRY.
  - test with no stored password -> stays IDLE.
- Collisions/reset:
  - set_password and key_valid in the same cycle -> SET_ENTRY with an empty buffer.
  - rst=0 during TEST_ENTRY -> all outputs 0 immediately, pw_valid=0.
- With LOCK_CTRL_BACKSPACE_EN: keys 1,2, B, 7 -> disp_digits 12'h017, cnt=2.
